// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage response tracker.
package mem_pkg;

  // Load/store type encodings carried with each tracked request.
  localparam logic [2:0] LD_ST = 3'd0;
  localparam logic [2:0] LD_W  = 3'd1;
  localparam logic [2:0] LD_B  = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  // Default data-bus width.
  localparam int DATA_W_DEF = 32;

  // Per-entry progress: waiting for bus data, or result captured.
  typedef enum logic {
    PEND = 1'b0,
    DONE = 1'b1
  } ent_state_e;

endpackage

// File: rtl/mem_load_align.sv
// Combinational load formatter: picks the byte/half/word lane addressed by
// addr_lo out of the raw bus data and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  localparam int ALSB   = $clog2(DATA_W / 8)
) (
  input  logic [2:0]        ld_type,
  input  logic [ALSB-1:0]   addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [31:0]       result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[ALSB-1:1], 4'b0000} +: 16];

  // A 64-bit bus carries two words; a 32-bit bus carries exactly one.
  if (DATA_W == 32) begin : g_word32
    assign word_v = rdata[31:0];
  end else begin : g_word64
    assign word_v = rdata[{addr_lo[ALSB-1:2], 5'b00000} +: 32];
  end

  // Extend the selected lane according to the load type; stores give zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = '0;
    case (ld_type)
      LD_W:    result = word_v;
      LD_B:    result = {{24{byte_v[7]}}, byte_v};
      LD_H:    result = {{16{half_v[15]}}, half_v};
      LD_BU:   result = {24'd0, byte_v};
      LD_HU:   result = {16'd0, half_v};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_resp_queue.sv
// In-order tracker for outstanding data-bus transactions. Entries are
// allocated on request, filled in order as bus data returns, and popped at
// the head by writeback. A flush converts every still-pending transaction
// into a drop credit so late bus responses are silently discarded.
module mem_resp_queue
  import mem_pkg::*;
#(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int ALSB   = $clog2(DATA_W / 8),
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int PW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_fire,
  input  logic [2:0]        req_ld_type,
  input  logic [ALSB-1:0]   req_addr_lo,
  output logic              req_ready,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_is_load,
  output logic [CW-1:0]     outstanding,
  output logic              busy
);

  // Control state.
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rsp_ptr_q, rsp_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  occ_q, occ_d;
  logic [CW-1:0]  drop_q, drop_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  ent_state_e     state_q [DEPTH];
  ent_state_e     state_d [DEPTH];

  // Entry payload.
  logic [2:0]      ld_type_q [DEPTH];
  logic [ALSB-1:0] addr_q    [DEPTH];
  logic [31:0]     result_q  [DEPTH];

  logic        fire_ok, drop_hit, pend_hit, pop;
  logic [CW-1:0] pend_cnt;
  logic [31:0] align_result;

  assign req_ready = ({1'b0, occ_q} + {1'b0, drop_q}) < (CW + 1)'(DEPTH);
  assign fire_ok   = req_fire & req_ready;
  assign drop_hit  = data_ok & (drop_q != '0);
  assign pend_hit  = data_ok & (drop_q == '0) & vld_q[rsp_ptr_q] &
                     (state_q[rsp_ptr_q] == PEND);
  assign pop       = resp_valid & resp_ready;

  // Count allocated entries still waiting for bus data.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && state_q[i] == PEND) pend_cnt = pend_cnt + 1'b1;
    end
  end

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .ld_type (ld_type_q[rsp_ptr_q]),
    .addr_lo (addr_q[rsp_ptr_q]),
    .rdata   (rdata),
    .result  (align_result)
  );

  // Next-state for pointers, counters and entry states; flush overrides all.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rsp_ptr_d = rsp_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = CW'(occ_q + CW'(fire_ok) - CW'(pop));
    drop_d    = CW'(drop_q - CW'(drop_hit));
    vld_d     = vld_q;
    state_d   = state_q;
    if (pend_hit) begin
      state_d[rsp_ptr_q] = DONE;
      rsp_ptr_d          = rsp_ptr_q + 1'b1;
    end
    if (fire_ok) begin
      vld_d[wr_ptr_q]   = 1'b1;
      state_d[wr_ptr_q] = PEND;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (flush) begin
      wr_ptr_d  = '0;
      rsp_ptr_d = '0;
      rd_ptr_d  = '0;
      occ_d     = '0;
      vld_d     = '0;
      for (int i = 0; i < DEPTH; i++) state_d[i] = PEND;
      drop_d = CW'(drop_q - CW'(drop_hit) + pend_cnt + CW'(fire_ok) - CW'(pend_hit));
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state.
    if (reset) begin
      wr_ptr_q  <= '0;
      rsp_ptr_q <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      drop_q    <= '0;
      vld_q     <= '0;
      for (int i = 0; i < DEPTH; i++) state_q[i] <= PEND;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rsp_ptr_q <= rsp_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      drop_q    <= drop_d;
      vld_q     <= vld_d;
      state_q   <= state_d;
    end
  end

  // Payload capture on allocation and on in-order data return.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is not reset; it is only observed through vld_q/state_q.
    if (fire_ok) begin
      ld_type_q[wr_ptr_q] <= req_ld_type;
      addr_q[wr_ptr_q]    <= req_addr_lo;
    end
    if (pend_hit) result_q[rsp_ptr_q] <= align_result;
  end

  assign resp_valid   = vld_q[rd_ptr_q] & (state_q[rd_ptr_q] == DONE);
  assign resp_data    = resp_valid ? result_q[rd_ptr_q] : 32'd0;
  assign resp_is_load = resp_valid & (ld_type_q[rd_ptr_q] != LD_ST);
  assign outstanding  = CW'(pend_cnt + drop_q);
  assign busy         = (occ_q != '0) | (drop_q != '0);

  // Protocol checks: no request while full, no response with nothing owed.
  a_req_when_ready : assert property (@(posedge clk) disable iff (reset)
    req_fire |-> req_ready);
  a_data_when_owed : assert property (@(posedge clk) disable iff (reset)
    data_ok |-> (drop_q != '0 || (vld_q[rsp_ptr_q] && state_q[rsp_ptr_q] == PEND)));

endmodule

// File: tb/tb_mem_resp_queue.sv
// Directed bench for mem_resp_queue: a 32-bit-bus instance exercises queue
// behaviour and flush/drop handling, a 64-bit-bus instance exercises lane
// selection.
module tb_mem_resp_queue;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit instance signals.
  logic        a_fire = 0, a_data_ok = 0, a_flush = 0, a_resp_ready = 0;
  logic [2:0]  a_type = 0;
  logic [1:0]  a_addr = 0;
  logic [31:0] a_rdata = 0;
  logic        a_req_ready, a_resp_valid, a_is_load, a_busy;
  logic [31:0] a_resp_data;
  logic [2:0]  a_out;

  // 64-bit instance signals.
  logic        b_fire = 0, b_data_ok = 0, b_flush = 0, b_resp_ready = 0;
  logic [2:0]  b_type = 0;
  logic [2:0]  b_addr = 0;
  logic [63:0] b_rdata = 0;
  logic        b_req_ready, b_resp_valid, b_is_load, b_busy;
  logic [31:0] b_resp_data;
  logic [2:0]  b_out;

  mem_resp_queue #(.DEPTH(4), .DATA_W(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_fire(a_fire), .req_ld_type(a_type), .req_addr_lo(a_addr),
    .req_ready(a_req_ready), .data_ok(a_data_ok), .rdata(a_rdata),
    .flush(a_flush), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_data(a_resp_data), .resp_is_load(a_is_load),
    .outstanding(a_out), .busy(a_busy)
  );

  mem_resp_queue #(.DEPTH(4), .DATA_W(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_fire(b_fire), .req_ld_type(b_type), .req_addr_lo(b_addr),
    .req_ready(b_req_ready), .data_ok(b_data_ok), .rdata(b_rdata),
    .flush(b_flush), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_data(b_resp_data), .resp_is_load(b_is_load),
    .outstanding(b_out), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic [2:0] t, input logic [1:0] a);
    a_fire = 1; a_type = t; a_addr = a;
    tick();
    a_fire = 0;
  endtask

  task automatic a_data(input logic [31:0] d);
    a_data_ok = 1; a_rdata = d;
    tick();
    a_data_ok = 0;
  endtask

  task automatic a_pop();
    a_resp_ready = 1;
    tick();
    a_resp_ready = 0;
  endtask

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;

    // Reset state.
    tick(); tick();
    reset = 0;
    check("rst_req_ready", a_req_ready, 1);
    check("rst_resp_valid", a_resp_valid, 0);
    check("rst_resp_data", a_resp_data, 0);
    check("rst_is_load", a_is_load, 0);
    check("rst_outstanding", a_out, 0);
    check("rst_busy", a_busy, 0);

    // ld.b at byte 3 of 0x80FF_0000 -> 0x80 sign-extended.
    a_req(mem_pkg::LD_B, 2'd3);
    check("ldb_out_pend", a_out, 1);
    check("ldb_no_valid_yet", a_resp_valid, 0);
    a_data(32'h80FF_0000);
    check("ldb_valid", a_resp_valid, 1);
    check("ldb_data", a_resp_data, 32'hFFFF_FF80);
    check("ldb_is_load", a_is_load, 1);
    a_pop();
    check("ldb_popped", a_resp_valid, 0);
    check("ldb_idle", a_busy, 0);

    // Same access as ld.bu -> zero-extended.
    a_req(mem_pkg::LD_BU, 2'd3);
    a_data(32'h80FF_0000);
    check("ldbu_data", a_resp_data, 32'h0000_0080);
    a_pop();

    // Store entry: completes with zero data, not a load.
    a_req(mem_pkg::LD_ST, 2'd0);
    a_data(32'hFFFF_FFFF);
    check("st32_valid", a_resp_valid, 1);
    check("st32_is_load", a_is_load, 0);
    check("st32_data", a_resp_data, 0);
    a_pop();

    // Four back-to-back ld.w fill the queue.
    for (int i = 0; i < 4; i++) a_req(mem_pkg::LD_W, 2'd0);
    check("full_req_ready", a_req_ready, 0);
    check("full_outstanding", a_out, 4);
    for (int i = 0; i < 4; i++) begin
      a_data(words[i]);
      check("fill_head_valid", a_resp_valid, 1);
      check("fill_head_stable", a_resp_data, 32'h11);
    end
    check("full_done_out", a_out, 0);
    check("full_done_ready", a_req_ready, 0);
    // Drain one per cycle with resp_ready held.
    a_resp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", a_resp_valid, 1);
      check("drain_data", a_resp_data, words[i]);
      tick();
    end
    a_resp_ready = 0;
    check("drain_empty", a_resp_valid, 0);
    check("drain_ready", a_req_ready, 1);
    check("drain_busy", a_busy, 0);

    // Three pending loads, flush together with a 4th request -> 4 drops.
    for (int i = 0; i < 3; i++) a_req(mem_pkg::LD_W, 2'd0);
    a_fire = 1; a_type = mem_pkg::LD_W; a_flush = 1;
    tick();
    a_fire = 0; a_flush = 0;
    check("flush4_out", a_out, 4);
    check("flush4_busy", a_busy, 1);
    check("flush4_ready", a_req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      a_data(32'hDEAD_0000 + 32'(i));
      check("flush4_dropped", a_resp_valid, 0);
    end
    check("flush4_out_end", a_out, 0);
    check("flush4_busy_end", a_busy, 0);
    a_req(mem_pkg::LD_W, 2'd0);
    a_data(32'hCAFE_BABE);
    check("post_flush_valid", a_resp_valid, 1);
    check("post_flush_data", a_resp_data, 32'hCAFE_BABE);
    a_pop();

    // Flush coinciding with data_ok for the oldest of two pending entries.
    a_req(mem_pkg::LD_W, 2'd0);
    a_req(mem_pkg::LD_W, 2'd0);
    a_data_ok = 1; a_rdata = 32'h1234_5678; a_flush = 1;
    tick();
    a_data_ok = 0; a_flush = 0;
    check("flushok_out", a_out, 1);
    check("flushok_valid", a_resp_valid, 0);
    a_data(32'h9999_9999);
    check("flushok_drop_valid", a_resp_valid, 0);
    check("flushok_busy", a_busy, 0);

    // Reset mid-operation with two in flight and one drop owed.
    a_req(mem_pkg::LD_W, 2'd0);
    a_flush = 1; tick(); a_flush = 0;
    a_req(mem_pkg::LD_W, 2'd0);
    a_req(mem_pkg::LD_W, 2'd0);
    check("prerst_out", a_out, 3);
    reset = 1;
    tick();
    reset = 0;
    check("midrst_out", a_out, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_ready", a_req_ready, 1);
    check("midrst_valid", a_resp_valid, 0);

    // 64-bit bus: ld.h at addr_lo=6 uses rdata[63:48].
    b_fire = 1; b_type = mem_pkg::LD_H; b_addr = 3'd6;
    tick();
    b_fire = 0;
    b_data_ok = 1; b_rdata = 64'h8001_0000_0000_0000;
    tick();
    b_data_ok = 0;
    check("b_ldh_valid", b_resp_valid, 1);
    check("b_ldh_data", b_resp_data, 32'hFFFF_8001);
    b_resp_ready = 1; tick(); b_resp_ready = 0;

    // 64-bit bus: ld.bu at addr_lo=7 uses rdata[63:56].
    b_fire = 1; b_type = mem_pkg::LD_BU; b_addr = 3'd7;
    tick();
    b_fire = 0;
    b_data_ok = 1; b_rdata = 64'hA500_0000_0000_00FF;
    tick();
    b_data_ok = 0;
    check("b_ldbu_data", b_resp_data, 32'h0000_00A5);
    b_resp_ready = 1; tick(); b_resp_ready = 0;

    // 64-bit bus: store entry.
    b_fire = 1; b_type = mem_pkg::LD_ST; b_addr = 3'd0;
    tick();
    b_fire = 0;
    b_data_ok = 1; b_rdata = '1;
    tick();
    b_data_ok = 0;
    check("b_st_valid", b_resp_valid, 1);
    check("b_st_is_load", b_is_load, 0);
    check("b_st_data", b_resp_data, 0);
    b_resp_ready = 1; tick(); b_resp_ready = 0;
    check("b_idle", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_resp_queue.md
# mem_resp_queue

Parametrised in-order tracker for outstanding data-bus transactions in the memory stage. It supports up to DEPTH accepted requests in flight and formats each load response (w/b/h/bu/hu) when it arrives. Completed results are held until the writeback stage accepts them. On flush it discards any number of stale responses, not just one, so the memory stage can issue back-to-back accesses.

## Interface
- DEPTH, 4: maximum outstanding transactions; power of two, ≥2.
- DATA_W, 32: bus data width; 32 or 64. ALSB = log2(DATA_W/8).
- CW, derived: $clog2(DEPTH+1), counter width.

- clk  in  1  clock; everything is sampled on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_fire  in  1  request accepted by bus this cycle (data_req & data_addr_ok).
- req_ld_type  in  3  0=store, 1=ld.w, 2=ld.b, 3=ld.h, 4=ld.bu, 5=ld.hu.
- req_addr_lo  in  ALSB  low address bits for lane select.
- req_ready  out  1  a new request may be issued.
- data_ok  in  1  bus response for the oldest outstanding transaction.
- rdata  in  DATA_W  raw read data, valid with data_ok.
- flush  in  1  exception/ertn flush; kills all tracked transactions.
- resp_valid  out  1  head entry has completed.
- resp_ready  in  1  writeback allowin.
- resp_data  out  32  formatted load result; 0 for stores.
- resp_is_load  out  1  head entry is a load.
- outstanding  out  CW  entries awaiting data, including ones to be dropped.
- busy  out  1  queue non-empty or drop_cnt ≠ 0.

## Operation
- Circular buffer of DEPTH entries. Each entry holds ld_type, addr_lo, state {PEND, DONE} and a 32-bit result.
- Three pointers of log2(DEPTH) bits each, all wrapping modulo DEPTH:
  - wr_ptr: allocation.
  - rsp_ptr: next entry to receive data.
  - rd_ptr: head.
- Counters: occ (allocated entries) and drop_cnt (stale responses still owed by the bus).
- req_ready = (occ + drop_cnt) < DEPTH. req_fire while req_ready = 0 is a protocol error: ignored and flagged by assertion.
- req_fire: write the entry at wr_ptr as PEND, wr_ptr++, occ++.
- data_ok handling:
  - drop_cnt > 0: drop_cnt--, rdata discarded.
  - Otherwise, an entry at rsp_ptr is PEND: format rdata, store the result, mark DONE, rsp_ptr++.
  - Otherwise (no pending entry): ignored and flagged by assertion.
- Formatting selects a byte/half lane of rdata by addr_lo:
  - Byte lane = addr_lo.
  - Half lane = addr_lo[ALSB-1:1].
  - Sign- or zero-extend according to ld_type.
  - Store entries yield 0.
- Head pop: when resp_valid & resp_ready, rd_ptr++ and occ--.
- flush:
  - drop_cnt ← drop_cnt + (PEND entries) + req_fire − (data_ok consumed by a PEND entry this cycle).
  - occ, pointers and all states are cleared; resp_valid ← 0 next cycle.
  - flush takes priority over pop and alloc.
- Simultaneous req_fire, data_ok and pop in one cycle are all legal and are applied together.

## Timing
- Reset values:
  - req_ready = 1.
  - resp_valid = 0, resp_data = 0, resp_is_load = 0.
  - outstanding = 0, busy = 0.
  - Pointers and counters = 0.
- Load-to-result latency: data_ok in cycle N gives resp_valid = 1 in cycle N+1 if that entry is at the head. No combinational path from data_ok to resp_*.
- Throughput is one response per cycle. A full queue with DONE entries drains at one per cycle while resp_ready is held high.
- resp_valid and resp_data are stable while resp_valid & !resp_ready.
- The occupancy decrement from a pop is visible to req_ready in the next cycle; there is no same-cycle bypass.
- Reset mid-operation clears drop_cnt. The bus is reset together with this block.

## Structure
- Shared package mem_pkg:
  - LD_* type encodings (LD_ST=0 … LD_HU=5).
  - DATA_W default.
  - Entry-state enum {PEND, DONE}.
- Sub-module mem_load_align, combinational: ld_type, addr_lo, rdata → 32-bit result. Instantiated once on the capture path.

## Test plan
- Single ld.b at addr_lo=3, rdata=0x80FF_0000 (DATA_W=32) → next cycle resp_valid=1, resp_data=0xFFFF_FF80. Same access as ld.bu → 0x0000_0080.
- Four back-to-back ld.w (DEPTH=4) → req_ready=0 after the 4th. data_ok ×4 with 0x11,0x22,0x33,0x44 while resp_ready=0; then resp_ready=1 → four pops in order on consecutive cycles.
- Three loads outstanding, flush in the same cycle as a 4th req_fire → drop_cnt=4, occ=0. Next four data_ok produce no resp_valid. A new load's data_ok then yields resp_valid=1.
- Flush coinciding with data_ok for the oldest of 2 PEND entries → drop_cnt=1 and no response is emitted.
- DATA_W=64, ld.h at addr_lo=6, rdata[63:48]=0x8001 → resp_data=0xFFFF_8001. Store entry → resp_is_load=0, resp_data=0.
- Reset asserted with 2 outstanding and drop_cnt=1 → next cycle outstanding=0, busy=0, req_ready=1.
